// File: rtl/edge_pkg.sv
// Shared types for the edge pulse generator: debounce FSM states and edge-select encodings.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'b00,
        CONFIRM_HIGH = 2'b01,
        IDLE_HIGH    = 2'b10,
        CONFIRM_LOW  = 2'b11
    } edge_state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam logic [7:0] GLITCH_COUNT_MAX = 8'hFF;

    // True when an accepted edge whose new level is new_level should produce a pulse under mode.
    function automatic logic mode_selects(input logic [1:0] mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = new_level;
            MODE_FALL: hit = ~new_level;
            MODE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser bringing an asynchronous level into the in_clock domain.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clock,
    input  logic in_reset_n,
    input  logic in_async,
    output logic out_sync
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], in_async};
        end
    end

    assign out_sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/edge_pulse_gen.sv
// Debounced edge detector: synchronises a raw level, confirms changes over DEBOUNCE_CYCLES,
// issues single-cycle pulses on selected edges and counts rejected glitches.
module edge_pulse_gen
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_signal,
    input  logic       in_enable,
    input  logic [1:0] in_mode,
    input  logic       in_clear,
    output logic       out_pulse,
    output logic       out_level,
    output logic [7:0] out_glitch_count
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_level;
    edge_state_t      state;
    edge_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             pulse_next;
    logic [7:0]       glitch_count_next;
    logic             accept;
    logic             glitch;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .in_async   (in_signal),
        .out_sync   (sync_level)
    );

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state            <= IDLE_LOW;
            cnt              <= '0;
            out_level        <= 1'b0;
            out_pulse        <= 1'b0;
            out_glitch_count <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            out_level        <= level_next;
            out_pulse        <= pulse_next;
            out_glitch_count <= glitch_count_next;
        end
    end

    // The counter only advances below CNT_MAX, so it cannot wrap; a mismatch mid-confirm is a glitch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = out_level;
        accept     = 1'b0;
        glitch     = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (sync_level) begin
                    state_next = CONFIRM_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!sync_level) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    glitch     = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_level) begin
                    state_next = CONFIRM_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            CONFIRM_LOW: begin
                if (sync_level) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    glitch     = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    level_next = 1'b0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Enable and mode only matter on the accepting edge, so suppressed edges are simply lost.
    always_comb begin
        pulse_next        = accept && in_enable && mode_selects(in_mode, level_next);
        glitch_count_next = out_glitch_count;
        if (in_clear) begin
            glitch_count_next = '0;
        end else if (glitch && (out_glitch_count != GLITCH_COUNT_MAX)) begin
            glitch_count_next = out_glitch_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Self-checking bench for edge_pulse_gen: directed scenarios plus a randomized run against a run-length model.
module tb_edge_pulse_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       in_clock;
    logic       in_reset_n;
    logic       in_signal;
    logic       in_enable;
    logic [1:0] in_mode;
    logic       in_clear;
    logic       out_pulse;
    logic       out_level;
    logic [7:0] out_glitch_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: raw history models the synchroniser delay, run counts consecutive disagreeing samples.
    bit         m_hist[$];
    bit         m_level;
    int         m_run;
    logic [7:0] m_count;
    bit         m_pulse;

    edge_pulse_gen #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .in_clock         (in_clock),
        .in_reset_n       (in_reset_n),
        .in_signal        (in_signal),
        .in_enable        (in_enable),
        .in_mode          (in_mode),
        .in_clear         (in_clear),
        .out_pulse        (out_pulse),
        .out_level        (out_level),
        .out_glitch_count (out_glitch_count)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        m_count = 8'd0;
        m_pulse = 1'b0;
    endtask

    task automatic model_edge(input bit sig, input bit en, input logic [1:0] mode, input bit clr);
        bit s;
        bit acc;
        bit gl;
        s   = m_hist.pop_front();
        m_hist.push_back(sig);
        acc = 1'b0;
        gl  = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
                acc     = 1'b1;
                m_level = s;
                m_run   = 0;
            end
        end else begin
            if (m_run > 0) gl = 1'b1;
            m_run = 0;
        end
        m_pulse = acc && en && ((mode == 2'b11) || (mode == 2'b01 && s) || (mode == 2'b10 && !s));
        if (clr) m_count = 8'd0;
        else if (gl && m_count != 8'd255) m_count = m_count + 8'd1;
    endtask

    task automatic drive_cycle(input logic sig, input logic en, input logic [1:0] mode, input logic clr);
        in_signal = sig;
        in_enable = en;
        in_mode   = mode;
        in_clear  = clr;
        @(posedge in_clock);
        model_edge(sig, en, mode, clr);
        #1;
    endtask

    task automatic do_reset(input logic sig);
        in_signal  = sig;
        in_enable  = 1'b1;
        in_mode    = 2'b01;
        in_clear   = 1'b0;
        in_reset_n = 1'b0;
        repeat (2) @(posedge in_clock);
        #4;
        in_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        in_signal  = 1'b0;
        in_enable  = 1'b1;
        in_mode    = 2'b01;
        in_clear   = 1'b0;
        in_reset_n = 1'b1;
        #1;
        in_reset_n = 1'b0;
        #1;
        checks++;
        if (out_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulse actual=%b expected=0", out_pulse); end
        checks++;
        if (out_level !== 1'b0) begin failures++; $display("[TB] FAIL reset_level actual=%b expected=0", out_level); end
        checks++;
        if (out_glitch_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_glitch_count actual=%0d expected=0", out_glitch_count); end
        repeat (2) @(posedge in_clock);
        #4;
        in_reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, 2'b01, 1'b0);
        checks++;
        if (out_level !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_level actual=%b expected=1", out_level); end
        in_reset_n = 1'b0;
        #2;
        checks++;
        if (out_level !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_level actual=%b expected=0", out_level); end
        #2;
        do_reset(1'b0);
    endtask

    task automatic test_rising_latency();
        int pulses;
        int idx;
        logic lvl6;
        pulses = 0;
        idx    = 0;
        lvl6   = 1'bx;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(1'b1, 1'b1, 2'b01, 1'b0);
            if (out_pulse) begin pulses++; idx = i; end
            if (i == 6) lvl6 = out_level;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("[TB] FAIL rise_pulse_count actual=%0d expected=1", pulses); end
        checks++;
        if (idx != 1 + SYNC + DEB) begin failures++; $display("[TB] FAIL rise_pulse_edge actual=%0d expected=%0d", idx, 1 + SYNC + DEB); end
        checks++;
        if (lvl6 !== 1'b0) begin failures++; $display("[TB] FAIL rise_level_early actual=%b expected=0", lvl6); end
        checks++;
        if (out_level !== 1'b1) begin failures++; $display("[TB] FAIL rise_level actual=%b expected=1", out_level); end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, 2'b11, 1'b0);
            if (out_pulse) pulses++;
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b1, 2'b11, 1'b0);
            if (out_pulse) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("[TB] FAIL glitch_pulses actual=%0d expected=0", pulses); end
        checks++;
        if (out_level !== 1'b0) begin failures++; $display("[TB] FAIL glitch_level actual=%b expected=0", out_level); end
        checks++;
        if (out_glitch_count !== 8'd1) begin failures++; $display("[TB] FAIL glitch_count actual=%0d expected=1", out_glitch_count); end
    endtask

    task automatic test_modes();
        int pulses;
        int first_idx;
        int last_idx;
        for (int pass = 0; pass < 2; pass++) begin
            logic [1:0] mode;
            mode      = (pass == 0) ? 2'b11 : 2'b10;
            pulses    = 0;
            first_idx = 0;
            last_idx  = 0;
            do_reset(1'b0);
            for (int i = 1; i <= 60; i++) begin
                drive_cycle((i <= 30) ? 1'b1 : 1'b0, 1'b1, mode, 1'b0);
                if (out_pulse) begin
                    pulses++;
                    if (first_idx == 0) first_idx = i;
                    last_idx = i;
                end
            end
            if (pass == 0) begin
                checks++;
                if (pulses != 2) begin failures++; $display("[TB] FAIL both_pulse_count actual=%0d expected=2", pulses); end
                checks++;
                if (first_idx != 7 || last_idx != 37) begin
                    failures++;
                    $display("[TB] FAIL both_pulse_edges actual=%0d,%0d expected=7,37", first_idx, last_idx);
                end
            end else begin
                checks++;
                if (pulses != 1) begin failures++; $display("[TB] FAIL fall_pulse_count actual=%0d expected=1", pulses); end
                checks++;
                if (first_idx != 37) begin failures++; $display("[TB] FAIL fall_pulse_edge actual=%0d expected=37", first_idx); end
            end
        end
    endtask

    task automatic test_enable_suppress();
        int pulses;
        int idx;
        pulses = 0;
        do_reset(1'b0);
        for (int i = 1; i <= 30; i++) begin
            drive_cycle(1'b1, (i > 10) ? 1'b1 : 1'b0, 2'b01, 1'b0);
            if (out_pulse) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("[TB] FAIL suppress_pulses actual=%0d expected=0", pulses); end
        checks++;
        if (out_level !== 1'b1) begin failures++; $display("[TB] FAIL suppress_level actual=%b expected=1", out_level); end

        // Enable and mode change while confirming; only their values on the accepting edge count.
        pulses = 0;
        idx    = 0;
        do_reset(1'b0);
        for (int i = 1; i <= 15; i++) begin
            drive_cycle(1'b1, (i > 4) ? 1'b1 : 1'b0, (i > 4) ? 2'b01 : 2'b00, 1'b0);
            if (out_pulse) begin pulses++; idx = i; end
        end
        checks++;
        if (pulses != 1 || idx != 7) begin
            failures++;
            $display("[TB] FAIL midconfirm_change actual=%0d@%0d expected=1@7", pulses, idx);
        end
    endtask

    task automatic test_glitch_saturation();
        int pulses;
        pulses = 0;
        do_reset(1'b0);
        for (int g = 0; g < 300; g++) begin
            for (int i = 0; i < 5; i++) begin
                drive_cycle((i < 2) ? 1'b1 : 1'b0, 1'b1, 2'b11, 1'b0);
                if (out_pulse) pulses++;
            end
        end
        checks++;
        if (out_glitch_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_count actual=%0d expected=255", out_glitch_count); end
        checks++;
        if (pulses != 0 || out_level !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_no_accept actual=%0d pulses level=%b expected=0 pulses level=0", pulses, out_level);
        end
        for (int i = 0; i < 4; i++) drive_cycle((i < 2) ? 1'b1 : 1'b0, 1'b1, 2'b11, 1'b0);
        checks++;
        if (out_glitch_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_hold actual=%0d expected=255", out_glitch_count); end
        drive_cycle(1'b0, 1'b1, 2'b11, 1'b1);
        checks++;
        if (out_glitch_count !== 8'd0) begin failures++; $display("[TB] FAIL clear_wins actual=%0d expected=0", out_glitch_count); end
    endtask

    task automatic test_reset_mid_confirm();
        int pulses;
        int idx;
        pulses = 0;
        idx    = 0;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) drive_cycle((i < 2) ? 1'b1 : 1'b0, 1'b1, 2'b01, 1'b0);
        checks++;
        if (out_glitch_count !== 8'd1) begin failures++; $display("[TB] FAIL pre_abort_count actual=%0d expected=1", out_glitch_count); end
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 2'b01, 1'b0);
        in_reset_n = 1'b0;
        #2;
        checks++;
        if (out_glitch_count !== 8'd0 || out_level !== 1'b0 || out_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_outputs actual=%0d/%b/%b expected=0/0/0", out_glitch_count, out_level, out_pulse);
        end
        @(posedge in_clock);
        @(posedge in_clock);
        #4;
        in_reset_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 20; i++) begin
            drive_cycle(1'b1, 1'b1, 2'b01, 1'b0);
            if (out_pulse) begin pulses++; idx = i; end
        end
        checks++;
        if (pulses != 1 || idx != 7) begin
            failures++;
            $display("[TB] FAIL post_abort_pulse actual=%0d@%0d expected=1@7", pulses, idx);
        end
        checks++;
        if (out_glitch_count !== 8'd0 || out_level !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_abort_state actual=%0d/%b expected=0/1", out_glitch_count, out_level);
        end
    endtask

    task automatic test_random();
        logic       sig;
        logic       en;
        logic [1:0] mode;
        logic       clr;
        int         hold_left;
        logic       prev_pulse;
        sig        = 1'b0;
        en         = 1'b1;
        mode       = 2'b11;
        hold_left  = 0;
        prev_pulse = 1'b0;
        do_reset(1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold_left == 0) begin
                sig       = 1'($urandom_range(0, 1));
                hold_left = int'($urandom_range(1, 9));
            end
            hold_left--;
            if ($urandom_range(0, 9) == 0) en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 79) == 0);
            drive_cycle(sig, en, mode, clr);
            checks++;
            if (out_pulse !== m_pulse) begin failures++; $display("[TB] FAIL rand_pulse cycle=%0d actual=%b expected=%b", cyc, out_pulse, m_pulse); end
            checks++;
            if (out_level !== m_level) begin failures++; $display("[TB] FAIL rand_level cycle=%0d actual=%b expected=%b", cyc, out_level, m_level); end
            checks++;
            if (out_glitch_count !== m_count) begin
                failures++;
                $display("[TB] FAIL rand_glitch_count cycle=%0d actual=%0d expected=%0d", cyc, out_glitch_count, m_count);
            end
            checks++;
            if (out_pulse === 1'b1 && prev_pulse === 1'b1) begin
                failures++;
                $display("[TB] FAIL back_to_back cycle=%0d actual=1,1 expected=no consecutive pulses", cyc);
            end
            prev_pulse = out_pulse;
        end
    endtask

    initial begin
        $display("[TB] starting edge_pulse_gen bench");
        test_reset();
        test_rising_latency();
        test_glitch();
        test_modes();
        test_enable_suppress();
        test_glitch_saturation();
        test_reset_mid_confirm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on in_signal; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronised cycles required to accept a level change; legal range 1..255.
REQ-003 in_clock  input  1  sole clock; all flops on its rising edge.
REQ-004 in_reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_signal  input  1  raw asynchronous level (button, sensor) to be edge-detected.
REQ-006 in_enable  input  1  synchronous; 1 = pulses may be issued, 0 = pulses suppressed.
REQ-007 in_mode  input  2  synchronous edge select: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 in_clear  input  1  synchronous; 1 = zero out_glitch_count.
REQ-009 out_pulse  output  1  registered single-cycle pulse per accepted edge matching in_mode; drives the downstream counter's enable.
REQ-010 out_level  output  1  registered debounced level.
REQ-011 out_glitch_count  output  8  registered saturating count of rejected glitches.

Function
REQ-012 in_signal shall pass through SYNC_STAGES flops before any other logic; no other logic shall use in_signal directly.
REQ-013 FSM states: IDLE_LOW, CONFIRM_HIGH, IDLE_HIGH, CONFIRM_LOW.
REQ-014 IDLE_LOW: sync=1 -> CONFIRM_HIGH, debounce counter=1; else stay.
REQ-015 CONFIRM_HIGH: sync=1 and counter<DEBOUNCE_CYCLES -> increment; sync=1 and counter=DEBOUNCE_CYCLES -> IDLE_HIGH, out_level<=1, rising edge accepted; sync=0 -> IDLE_LOW, counter<=0, glitch rejected.
REQ-016 IDLE_HIGH / CONFIRM_LOW: mirror of REQ-014/015 with polarity inverted; acceptance gives out_level<=0 and a falling edge.
REQ-017 Debounce counter width $clog2(DEBOUNCE_CYCLES+1); the counter shall never wrap.
REQ-018 Latency: a clean input transition setting up before clock edge t0 shall drive out_level and out_pulse high after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES, for one cycle in the case of out_pulse.
REQ-019 out_pulse=1 only in the cycle after acceptance, and only if in_enable=1 and in_mode matches the edge direction, both sampled on the accepting edge.
REQ-020 in_enable=0 or in_mode=00: FSM, out_level and glitch counting continue; suppressed edges shall not be replayed later.
REQ-021 out_pulse shall never be high on two consecutive cycles.
REQ-022 Glitch rejection shall increment out_glitch_count by 1, holding at 255 (no wrap to 0).
REQ-023 in_clear=1 in the same cycle as a glitch rejection: out_glitch_count becomes 0 (clear wins).
REQ-024 in_mode or in_enable changes during CONFIRM_* shall not disturb the FSM or debounce counter.

Reset
REQ-025 in_reset_n=0 shall immediately, without a clock, force: synchroniser flops 0, FSM IDLE_LOW, debounce counter 0, out_pulse 0, out_level 0, out_glitch_count 0.
REQ-026 After reset release with in_signal held high, the block shall accept a rising edge per REQ-018; this is valid behaviour.
REQ-027 Reset asserted mid-CONFIRM shall abandon the confirmation; no pulse is issued and no glitch is counted.

Structure
REQ-028 Package edge_pkg shall hold the FSM state enum and the in_mode encodings (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH).
REQ-029 The synchroniser shall be a sub-module edge_sync (parameter SYNC_STAGES, async active-low reset), instantiated once.
REQ-030 FSM, debounce counter, pulse generation and glitch counter shall live in edge_pulse_gen.

Verification
REQ-031 Defaults, mode=01, enable=1, in_signal 0->1 held 20 cycles -> out_pulse high exactly 1 cycle, 6 edges after the transition; out_level=1.
REQ-032 in_signal high for 3 cycles, then low (DEBOUNCE_CYCLES=4) -> no out_pulse, out_level stays 0, out_glitch_count=1.
REQ-033 mode=11, clean 0->1->0 edges 30 cycles apart -> exactly 2 pulses; mode=10, same stimulus -> 1 pulse, on the falling edge only.
REQ-034 enable=0 during a rising edge, then enable=1 -> no pulse ever for that edge; out_level=1.
REQ-035 300 glitches -> out_glitch_count=255; in_clear=1 coincident with the next glitch -> 0.
REQ-036 Reset pulsed low mid-CONFIRM_HIGH -> all outputs 0 immediately; held-high input then yields 1 pulse, 6 cycles after release.
